// File: rtl/bitslice_alu_n_if.sv
// ---------------------------------------------------------------------------
// bitslice_alu_n_if
//
// Purpose: groups the microinstruction, addressing, data, status and
// shift-pin signals of bitslice_alu_n into one bundle. Clock, reset and the
// three-state data output y are kept as plain ports on the slice itself.
//
// Signals (direction as seen by the slice, modport slave):
//   en                 in   write enable (0 holds all state)
//   i[8:0]             in   microinstruction {dest[8:6], func[5:3], src[2:0]}
//   a, b [AW-1:0]      in   register-file read (A) and read/write (B) addresses
//   d [WIDTH-1:0]      in   direct data input
//   cin                in   ALU carry-in
//   oe                 in   output enable for y
//   cout/ovr/z/f_msb   out  ALU status
//   g_lo/p_lo          out  active-low group generate / propagate
//   *_in               in   shift-in pins for RAM and Q shifter ends
//   *_out, *_oe        out  shift-out data and its drive enable
//   flags[3:0]         out  registered {cout, ovr, z, f_msb}, only when the
//                           FLAG_REG_EN macro is defined
// ---------------------------------------------------------------------------
interface bitslice_alu_n_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic             en;
  logic [8:0]       i;
  logic [AW-1:0]    a;
  logic [AW-1:0]    b;
  logic [WIDTH-1:0] d;
  logic             cin;
  logic             oe;

  logic             cout;
  logic             ovr;
  logic             z;
  logic             f_msb;
  logic             g_lo;
  logic             p_lo;

  logic             ram_lo_in;
  logic             ram_hi_in;
  logic             q_lo_in;
  logic             q_hi_in;

  logic             ram_lo_out;
  logic             ram_hi_out;
  logic             q_lo_out;
  logic             q_hi_out;

  logic             ram_lo_oe;
  logic             ram_hi_oe;
  logic             q_lo_oe;
  logic             q_hi_oe;

`ifdef FLAG_REG_EN
  logic [3:0]       flags;
`endif

  // Controller / bench side.
  modport master (
    output en, i, a, b, d, cin, oe,
    output ram_lo_in, ram_hi_in, q_lo_in, q_hi_in,
    input  cout, ovr, z, f_msb, g_lo, p_lo,
    input  ram_lo_out, ram_hi_out, q_lo_out, q_hi_out,
    input  ram_lo_oe, ram_hi_oe, q_lo_oe, q_hi_oe
`ifdef FLAG_REG_EN
    , input flags
`endif
  );

  // Slice side.
  modport slave (
    input  en, i, a, b, d, cin, oe,
    input  ram_lo_in, ram_hi_in, q_lo_in, q_hi_in,
    output cout, ovr, z, f_msb, g_lo, p_lo,
    output ram_lo_out, ram_hi_out, q_lo_out, q_hi_out,
    output ram_lo_oe, ram_hi_oe, q_lo_oe, q_hi_oe
`ifdef FLAG_REG_EN
    , output flags
`endif
  );
endinterface

// File: rtl/bitslice_alu_n.sv
// ---------------------------------------------------------------------------
// bitslice_alu_n
//
// Purpose: a parameterised 2901-style bit-slice ALU. A dual-ported register
// file (A read, B read/write) and a Q register feed an operand selector and
// an eight-function ALU; the result F can be written back to RF[b] or Q,
// optionally shifted one place up or down with shift-in/shift-out pins at
// both ends of the slice so slices can be cascaded.
//
// Parameters:
//   WIDTH  datapath width (4..32)
//   NREGS  register-file depth (power of two, 2..64)
//   AW     register address width, log2(NREGS)
//
// Ports:
//   cp    in   clock, all state updates on its rising edge
//   rst   in   asynchronous active-high reset (clears RF, Q, flags)
//   bus   --   bitslice_alu_n_if.slave: instruction, addresses, data,
//              status, carry-lookahead and shift pins
//   y     out  data output, all-Z when bus.oe = 0
//
// Optional feature: define FLAG_REG_EN to add the registered status port
// bus.flags = {cout, ovr, z, f_msb}, updated on enabled edges that execute
// an arithmetic function. Without it the status outputs are combinational
// only and no flag register exists.
// ---------------------------------------------------------------------------
module bitslice_alu_n #(
  parameter int WIDTH = 8,
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic                 cp,
  input  logic                 rst,
  bitslice_alu_n_if.slave      bus,
  output wire  [WIDTH-1:0]     y
);

  // -------------------------------------------------------------------------
  // Microinstruction fields
  // -------------------------------------------------------------------------
  logic [2:0] src_sel;
  logic [2:0] fn_sel;
  logic [2:0] dst_sel;

  assign src_sel = bus.i[2:0];
  assign fn_sel  = bus.i[5:3];
  assign dst_sel = bus.i[8:6];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  // The register file is cleared asynchronously, so it is built from plain
  // flops rather than a block RAM; both ports read combinationally.
  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] qreg_q;
  logic [WIDTH-1:0] qreg_d;

  logic [AW-1:0]    a_idx;
  logic [AW-1:0]    b_idx;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;

  assign a_idx  = bus.a;
  assign b_idx  = bus.b;
  // With a == b both ports simply index the same entry, so they agree.
  assign a_data = rf_q[a_idx];
  assign b_data = rf_q[b_idx];

  // -------------------------------------------------------------------------
  // Operand selection (R, S)
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] s_op;

  always_comb begin
    r_op = '0;
    s_op = '0;
    case (src_sel)
      3'd0: begin r_op = a_data; s_op = qreg_q; end
      3'd1: begin r_op = a_data; s_op = b_data; end
      3'd2: begin r_op = '0;     s_op = qreg_q; end
      3'd3: begin r_op = '0;     s_op = b_data; end
      3'd4: begin r_op = '0;     s_op = a_data; end
      3'd5: begin r_op = bus.d;  s_op = a_data; end
      3'd6: begin r_op = bus.d;  s_op = qreg_q; end
      default: begin r_op = bus.d; s_op = '0; end
    endcase
  end

  // -------------------------------------------------------------------------
  // Adder: the three arithmetic functions are all X + Y + cin with one
  // operand optionally inverted, so a single carry chain serves them all.
  // -------------------------------------------------------------------------
  logic             is_arith;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_bit;

  assign is_arith = (fn_sel <= 3'd2);
  assign add_x    = (fn_sel == 3'd1) ? ~r_op : r_op;
  assign add_y    = (fn_sel == 3'd2) ? ~s_op : s_op;

  // Per-bit generate/propagate terms; propagate uses the OR form so the
  // group signals satisfy cout = G | (P & cin).
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_gp
      assign p_bit[gi] = add_x[gi] | add_y[gi];
      assign g_bit[gi] = add_x[gi] & add_y[gi];
    end
  endgenerate

  logic [WIDTH:0]   carry;     // carry[k] = carry into bit k
  logic [WIDTH:0]   gen_chain; // same chain with carry-in forced to 0
  logic [WIDTH-1:0] sum;

  always_comb begin
    carry        = '0;
    gen_chain    = '0;
    carry[0]     = bus.cin;
    gen_chain[0] = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      carry[k+1]     = g_bit[k] | (p_bit[k] & carry[k]);
      gen_chain[k+1] = g_bit[k] | (p_bit[k] & gen_chain[k]);
    end
    sum = add_x ^ add_y ^ carry[WIDTH-1:0];
  end

  // -------------------------------------------------------------------------
  // Function result F and status
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] f_val;
  logic             cout_w;
  logic             ovr_w;
  logic             g_lo_w;
  logic             p_lo_w;
  logic             z_w;
  logic             f_msb_w;

  always_comb begin
    f_val = sum;
    case (fn_sel)
      3'd3:    f_val = r_op | s_op;
      3'd4:    f_val = r_op & s_op;
      3'd5:    f_val = ~r_op & s_op;
      3'd6:    f_val = r_op ^ s_op;
      3'd7:    f_val = ~(r_op ^ s_op);
      default: f_val = sum;
    endcase
  end

  // Logic functions report no carry activity and idle lookahead levels.
  assign cout_w  = is_arith ? carry[WIDTH] : 1'b0;
  assign ovr_w   = is_arith ? (carry[WIDTH] ^ carry[WIDTH-1]) : 1'b0;
  assign g_lo_w  = is_arith ? ~gen_chain[WIDTH] : 1'b1;
  assign p_lo_w  = is_arith ? ~(&p_bit) : 1'b1;
  assign z_w     = (f_val == '0);
  assign f_msb_w = f_val[WIDTH-1];

  assign bus.cout  = cout_w;
  assign bus.ovr   = ovr_w;
  assign bus.g_lo  = g_lo_w;
  assign bus.p_lo  = p_lo_w;
  assign bus.z     = z_w;
  assign bus.f_msb = f_msb_w;

  // -------------------------------------------------------------------------
  // Destination decode: what gets written where on the next enabled edge
  // -------------------------------------------------------------------------
  logic             rf_wr;
  logic [WIDTH-1:0] rf_wdata;

  always_comb begin
    rf_wr    = 1'b0;
    rf_wdata = f_val;
    qreg_d   = qreg_q;
    case (dst_sel)
      3'd0: qreg_d = f_val;
      3'd1: ; // no state change
      3'd2, 3'd3: rf_wr = 1'b1;
      3'd4: begin
        rf_wr    = 1'b1;
        rf_wdata = {bus.ram_hi_in, f_val[WIDTH-1:1]};
        qreg_d   = {bus.q_hi_in, qreg_q[WIDTH-1:1]};
      end
      3'd5: begin
        rf_wr    = 1'b1;
        rf_wdata = {bus.ram_hi_in, f_val[WIDTH-1:1]};
      end
      3'd6: begin
        rf_wr    = 1'b1;
        rf_wdata = {f_val[WIDTH-2:0], bus.ram_lo_in};
        qreg_d   = {qreg_q[WIDTH-2:0], bus.q_lo_in};
      end
      default: begin
        rf_wr    = 1'b1;
        rf_wdata = {f_val[WIDTH-2:0], bus.ram_lo_in};
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Shift-out pins: only the end of the shifter that bits fall out of
  // drives, and its data is held low when not driving.
  // -------------------------------------------------------------------------
  logic ram_lo_oe_w;
  logic ram_hi_oe_w;
  logic q_lo_oe_w;
  logic q_hi_oe_w;

  assign ram_lo_oe_w = (dst_sel == 3'd4) || (dst_sel == 3'd5);
  assign ram_hi_oe_w = (dst_sel == 3'd6) || (dst_sel == 3'd7);
  assign q_lo_oe_w   = (dst_sel == 3'd4);
  assign q_hi_oe_w   = (dst_sel == 3'd6);

  assign bus.ram_lo_oe  = ram_lo_oe_w;
  assign bus.ram_hi_oe  = ram_hi_oe_w;
  assign bus.q_lo_oe    = q_lo_oe_w;
  assign bus.q_hi_oe    = q_hi_oe_w;
  assign bus.ram_lo_out = ram_lo_oe_w & f_val[0];
  assign bus.ram_hi_out = ram_hi_oe_w & f_val[WIDTH-1];
  assign bus.q_lo_out   = q_lo_oe_w & qreg_q[0];
  assign bus.q_hi_out   = q_hi_oe_w & qreg_q[WIDTH-1];

  // -------------------------------------------------------------------------
  // Data output: destination 2 exposes the A-port contents instead of F.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] y_val;

  assign y_val = (dst_sel == 3'd2) ? a_data : f_val;
  assign y     = bus.oe ? y_val : {WIDTH{1'bz}};

  // -------------------------------------------------------------------------
  // Optional registered status
  // -------------------------------------------------------------------------
`ifdef FLAG_REG_EN
  logic [3:0] flags_q;
  logic [3:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (is_arith) begin
      flags_d = {cout_w, ovr_w, z_w, f_msb_w};
    end
  end

  assign bus.flags = flags_q;
`endif

  // -------------------------------------------------------------------------
  // Sequential state. Reset is asynchronous, so an edge that coincides with
  // reset assertion leaves nothing behind.
  // -------------------------------------------------------------------------
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        rf_q[k] <= '0;
      end
      qreg_q <= '0;
`ifdef FLAG_REG_EN
      flags_q <= '0;
`endif
    end else if (bus.en) begin
      qreg_q <= qreg_d;
      if (rf_wr) begin
        rf_q[b_idx] <= rf_wdata;
      end
`ifdef FLAG_REG_EN
      flags_q <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_bitslice_alu_n.sv
module tb_bitslice_alu_n;

  logic cp  = 1'b0;
  logic rst = 1'b0;
  wire  [7:0] y;

  bitslice_alu_n_if #(.WIDTH(8), .AW(4)) bus ();

  bitslice_alu_n #(.WIDTH(8), .NREGS(16), .AW(4)) dut (
    .cp  (cp),
    .rst (rst),
    .bus (bus.slave),
    .y   (y)
  );

  always #5 cp = ~cp;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // ---------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------
  logic [7:0] rf_m [16];
  logic [7:0] q_m;
`ifdef FLAG_REG_EN
  logic [3:0] fl_m;
`endif

  logic [7:0] m_f, m_y;
  logic       m_co, m_ov, m_gl, m_pl;

  function automatic logic [8:0] mk_i(input int dst, input int fn, input int src);
    return 9'((dst << 6) | (fn << 3) | src);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected combinational results from plain integer arithmetic.
  function automatic void model_comb(output logic [7:0] f, output logic [7:0] yv,
                                     output logic co, output logic ov,
                                     output logic gl, output logic pl);
    logic [7:0] av, bv, r, s, o1, o2;
    int src, fn, dst, sum, ss;
    av  = rf_m[bus.a];
    bv  = rf_m[bus.b];
    src = int'(bus.i[2:0]);
    fn  = int'(bus.i[5:3]);
    dst = int'(bus.i[8:6]);
    case (src)
      0: begin r = av;    s = q_m;  end
      1: begin r = av;    s = bv;   end
      2: begin r = 8'h00; s = q_m;  end
      3: begin r = 8'h00; s = bv;   end
      4: begin r = 8'h00; s = av;   end
      5: begin r = bus.d; s = av;   end
      6: begin r = bus.d; s = q_m;  end
      default: begin r = bus.d; s = 8'h00; end
    endcase
    co = 1'b0; ov = 1'b0; gl = 1'b1; pl = 1'b1;
    f  = 8'h00;
    if (fn < 3) begin
      o1  = (fn == 1) ? ~r : r;
      o2  = (fn == 2) ? ~s : s;
      sum = int'(o1) + int'(o2) + int'(bus.cin);
      f   = 8'(sum);
      co  = (sum > 255);
      ss  = int'($signed(o1)) + int'($signed(o2)) + int'(bus.cin);
      ov  = (ss > 127) || (ss < -128);
      gl  = !((int'(o1) + int'(o2)) > 255);
      pl  = !((o1 | o2) == 8'hFF);
    end else begin
      case (fn)
        3: f = r | s;
        4: f = r & s;
        5: f = ~r & s;
        6: f = r ^ s;
        default: f = ~(r ^ s);
      endcase
    end
    yv = (dst == 2) ? av : f;
  endfunction

  always_comb model_comb(m_f, m_y, m_co, m_ov, m_gl, m_pl);

  // Model state update.
  always @(posedge cp or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) rf_m[k] <= 8'h00;
      q_m <= 8'h00;
`ifdef FLAG_REG_EN
      fl_m <= 4'h0;
`endif
    end else if (bus.en) begin
      case (int'(bus.i[8:6]))
        0: q_m <= m_f;
        2, 3: rf_m[bus.b] <= m_f;
        4: begin
          rf_m[bus.b] <= (m_f >> 1) | (8'(bus.ram_hi_in) << 7);
          q_m         <= (q_m >> 1) | (8'(bus.q_hi_in) << 7);
        end
        5: rf_m[bus.b] <= (m_f >> 1) | (8'(bus.ram_hi_in) << 7);
        6: begin
          rf_m[bus.b] <= (m_f << 1) | 8'(bus.ram_lo_in);
          q_m         <= (q_m << 1) | 8'(bus.q_lo_in);
        end
        7: rf_m[bus.b] <= (m_f << 1) | 8'(bus.ram_lo_in);
        default: ;
      endcase
`ifdef FLAG_REG_EN
      if (int'(bus.i[5:3]) < 3) fl_m <= {m_co, m_ov, (m_f == 8'h00), m_f[7]};
`endif
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge cp) begin
    if (chk_on) begin
      int dst;
      dst = int'(bus.i[8:6]);
      if (bus.oe) check("y", y, m_y);
      check("cout",  bus.cout,  m_co);
      check("ovr",   bus.ovr,   m_ov);
      check("z",     bus.z,     (m_f == 8'h00));
      check("f_msb", bus.f_msb, m_f[7]);
      check("g_lo",  bus.g_lo,  m_gl);
      check("p_lo",  bus.p_lo,  m_pl);
      check("ram_lo_oe", bus.ram_lo_oe, (dst == 4 || dst == 5));
      check("ram_hi_oe", bus.ram_hi_oe, (dst == 6 || dst == 7));
      check("q_lo_oe",   bus.q_lo_oe,   (dst == 4));
      check("q_hi_oe",   bus.q_hi_oe,   (dst == 6));
      if (dst == 4 || dst == 5) check("ram_lo_out", bus.ram_lo_out, m_f[0]);
      if (dst == 6 || dst == 7) check("ram_hi_out", bus.ram_hi_out, m_f[7]);
      if (dst == 4) check("q_lo_out", bus.q_lo_out, q_m[0]);
      if (dst == 6) check("q_hi_out", bus.q_hi_out, q_m[7]);
`ifdef FLAG_REG_EN
      check("flags", bus.flags, fl_m);
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic op(input int src, input int fn, input int dst, input int av, input int bv,
                    input logic [7:0] dv, input logic c, input logic e);
    bus.i   = mk_i(dst, fn, src);
    bus.a   = 4'(av);
    bus.b   = 4'(bv);
    bus.d   = dv;
    bus.cin = c;
    bus.en  = e;
    bus.oe  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ram_lo_in = 1'b0; bus.ram_hi_in = 1'b0;
    bus.q_lo_in   = 1'b0; bus.q_hi_in   = 1'b0;
    op(4, 0, 1, 3, 0, 8'h00, 1'b0, 1'b0);

    // Reset state.
    #1 rst = 1'b1;
    #2 check("reset_y", y, 32'h00);
    chk_on = 1'b1;
    op(7, 0, 3, 0, 3, 8'hFF, 1'b0, 1'b1);   // ignored during reset
    tick(); tick();
    rst = 1'b0;
    op(4, 0, 1, 3, 0, 8'h00, 1'b0, 1'b0);
    #1 check("reset_rf3", y, 32'h00);
    tick();

    // Write 0xA5 to RF[3], then an asynchronous mid-cycle reset.
    op(7, 0, 3, 0, 3, 8'hA5, 1'b0, 1'b1);
    tick();
    op(4, 0, 1, 3, 0, 8'h00, 1'b0, 1'b0);
    #1 check("rf3_a5", y, 32'hA5);
    #1 rst = 1'b1;
    #1 check("async_rst_y", y, 32'h00);
    #2 rst = 1'b0;
    tick();

    // Reset coinciding with a write edge: the write must not survive.
    op(7, 0, 3, 0, 7, 8'h3C, 1'b0, 1'b1);
    @(posedge cp);
    rst = 1'b1;
    #1 rst = 1'b0;
    op(4, 0, 1, 7, 0, 8'h00, 1'b0, 1'b0);
    #1 check("edge_rst_rf7", y, 32'h00);
    tick();

    // Add with carry into MSB: 0x7F + 0x01.
    op(7, 0, 3, 0, 1, 8'h7F, 1'b0, 1'b1);
    tick();
    op(5, 0, 3, 1, 2, 8'h01, 1'b0, 1'b1);
    #1;
    check("add_f",    y,         32'h80);
    check("add_ovr",  bus.ovr,   32'h1);
    check("add_cout", bus.cout,  32'h0);
    check("add_z",    bus.z,     32'h0);
    check("add_msb",  bus.f_msb, 32'h1);
    tick();
    op(4, 0, 1, 2, 0, 8'h00, 1'b0, 1'b0);
    #1 check("add_rf2", y, 32'h80);
    tick();

    // Subtract to zero: D - A with cin=1.
    op(7, 0, 3, 0, 4, 8'h33, 1'b0, 1'b1);
    tick();
    op(5, 2, 1, 4, 0, 8'h33, 1'b1, 1'b1);
    #1;
    check("sub_f",    y,        32'h00);
    check("sub_z",    bus.z,    32'h1);
    check("sub_cout", bus.cout, 32'h1);
    check("sub_ovr",  bus.ovr,  32'h0);
    tick();
`ifdef FLAG_REG_EN
    check("flag_z_set", bus.flags[1], 32'h1);
    op(7, 3, 1, 0, 0, 8'hFF, 1'b0, 1'b1);
    tick();
    check("flag_z_hold", bus.flags[1], 32'h1);
`endif

    // Down shift: Q=0x81, F=0x02, ram_hi_in=1, q_hi_in=0.
    op(7, 0, 0, 0, 0, 8'h81, 1'b0, 1'b1);
    tick();
    op(7, 0, 4, 0, 6, 8'h02, 1'b0, 1'b1);
    bus.ram_hi_in = 1'b1;
    bus.q_hi_in   = 1'b0;
    #1;
    check("dsh_ram_lo_oe",  bus.ram_lo_oe,  32'h1);
    check("dsh_ram_lo_out", bus.ram_lo_out, 32'h0);
    check("dsh_q_lo_oe",    bus.q_lo_oe,    32'h1);
    check("dsh_q_lo_out",   bus.q_lo_out,   32'h1);
    tick();
    bus.ram_hi_in = 1'b0;
    op(4, 0, 1, 6, 0, 8'h00, 1'b0, 1'b0);
    #1 check("dsh_rf6", y, 32'h81);
    op(2, 0, 1, 0, 0, 8'h00, 1'b0, 1'b0);
    #1 check("dsh_q", y, 32'h40);
    tick();

    // Hold while en=0, A-port on y for dest 2, and oe=0.
    op(7, 0, 3, 0, 6, 8'hFF, 1'b0, 1'b0);
    tick();
    op(4, 0, 1, 6, 0, 8'h00, 1'b0, 1'b0);
    #1 check("hold_rf6", y, 32'h81);
    op(7, 0, 3, 0, 5, 8'h5A, 1'b0, 1'b1);
    tick();
    op(7, 0, 2, 5, 0, 8'h00, 1'b0, 1'b0);
    #1 check("ymux_a", y, 32'h5A);
    bus.oe = 1'b0;
    #1 check("oe_off_not_driven", (y === 8'h5A), 32'h0);
    bus.oe = 1'b1;
    tick();

    // Randomised phase against the model.
    for (int n = 0; n < 500; n++) begin
      bus.i   = 9'($urandom);
      bus.a   = 4'($urandom);
      bus.b   = ($urandom_range(0, 7) == 0) ? bus.a : 4'($urandom);
      bus.d   = 8'($urandom);
      bus.cin = 1'($urandom);
      bus.en  = ($urandom_range(0, 3) != 0);
      bus.oe  = ($urandom_range(0, 7) != 0);
      bus.ram_lo_in = 1'($urandom);
      bus.ram_hi_in = 1'($urandom);
      bus.q_lo_in   = 1'($urandom);
      bus.q_hi_in   = 1'($urandom);
      tick();
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bitslice_alu_n.md
BITSLICE_ALU_N -- requirements
Module: bitslice_alu_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits (legal: 4..32).
REQ-002 SHALL have parameter NREGS, default 16, register-file depth (power of two, 2..64).
REQ-003 SHALL have parameter AW, default 4, register address width, equal to log2(NREGS).
REQ-004 SHALL have ports (name  direction  width  meaning):
- cp  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  write enable; 0 holds all state.
- i  in  9  microinstruction: [2:0] source, [5:3] function, [8:6] destination.
- a, b  in  AW  register addresses (A read port; B read/write port).
- d  in  WIDTH  direct data input.
- cin  in  1  ALU carry-in.
- oe  in  1  output enable; 0 drives y to all-Z.
- y  out  WIDTH  data output.
- cout, ovr, z, f_msb  out  1 each  carry-out, signed overflow, F==0, F[WIDTH-1].
- g_lo, p_lo  out  1 each  active-low carry-lookahead generate/propagate.
- ram_lo_in, ram_hi_in, q_lo_in, q_hi_in  in  1 each  shift-in pins.
- ram_lo_out, ram_hi_out, q_lo_out, q_hi_out  out  1 each  shift-out data.
- ram_lo_oe, ram_hi_oe, q_lo_oe, q_hi_oe  out  1 each  shift-out drive enables.
- flags  out  4  registered {cout, ovr, z, f_msb}; present only with FLAG_REG_EN.

Function
REQ-005 SHALL select R,S by i[2:0]: 0 A,Q; 1 A,B; 2 0,Q; 3 0,B; 4 0,A; 5 D,A; 6 D,Q; 7 D,0.
REQ-006 SHALL compute F by i[5:3]: 0 R+S+cin; 1 S+~R+cin; 2 R+~S+cin; 3 R|S; 4 R&S; 5 ~R&S; 6 R^S; 7 ~(R^S).
REQ-007 SHALL produce cout, ovr (carry into MSB XOR carry out of MSB), g_lo and p_lo from the full-width adder for arithmetic functions; for logic functions cout=0, ovr=0, g_lo=1, p_lo=1.
REQ-008 SHALL drive z=1 iff F is all zeros, and f_msb=F[WIDTH-1], combinationally.
REQ-009 SHALL act by i[8:6] on the rising edge when en=1: 0 Q<=F; 1 none; 2 and 3 RF[b]<=F; 4 RF[b]<={ram_hi_in,F[W-1:1]}, Q<={q_hi_in,Q[W-1:1]}; 5 RF[b] shifted down as in 4, Q held; 6 RF[b]<={F[W-2:0],ram_lo_in}, Q<={Q[W-2:0],q_lo_in}; 7 RF[b] shifted up as in 6, Q held.
REQ-010 SHALL drive y=A-port data for destination 2, F otherwise, when oe=1.
REQ-011 SHALL assert ram_lo_oe with ram_lo_out=F[0] for destinations 4,5, and ram_hi_oe with ram_hi_out=F[W-1] for destinations 6,7; all other shift enables deasserted.
REQ-012 SHALL assert q_lo_oe with q_lo_out=Q[0] for destination 4, and q_hi_oe with q_hi_out=Q[W-1] for destination 6.
REQ-013 SHALL read A and B ports combinationally; when a==b, both ports return the same pre-edge value.
REQ-014 SHALL make a write to RF[b] visible on the read ports only after the clock edge (no write-through).
REQ-015 SHALL hold RF, Q and flags unchanged while en=0; combinational outputs SHALL still follow the inputs.

Reset
REQ-016 SHALL, on rst=1, immediately clear every RF entry, Q and flags to 0, independent of cp.
REQ-017 SHALL ignore en and i while rst=1; the first write occurs on the first rising cp edge after rst falls.
REQ-018 SHALL abort an edge coinciding with rst assertion; no partial write survives.

Configuration
REQ-019 With FLAG_REG_EN defined, the block SHALL latch {cout,ovr,z,f_msb} into flags on each enabled edge with an arithmetic function (i[5:3]<=2) and hold flags otherwise.
REQ-020 Without FLAG_REG_EN, the flags port and its register SHALL be absent; status outputs stay combinational only.

Verification (WIDTH=8, NREGS=16)
REQ-021 Reset: write 0xA5 to RF[3], pulse rst mid-cycle -> y=0x00 immediately with i=source 4 (0,A), a=3, dest 1.
REQ-022 Add with carry: RF[1]=0x7F, d=0x01, cin=0, i=source 5, function 0, dest 3, b=2 -> F=0x80, ovr=1, cout=0, z=0, f_msb=1; RF[2]=0x80 after the edge.
REQ-023 Subtract to zero: RF[4]=0x33, d=0x33, i=source 5, function 2, cin=1 -> F=0x00, z=1, cout=1, ovr=0.
REQ-024 Down shift: Q=0x81, F=0x02, ram_hi_in=1, q_hi_in=0, dest 4 -> RF[b]=0x81, Q=0x40, ram_lo_out=0 with oe=1, q_lo_out=1 with oe=1.
REQ-025 Hold and y mux: en=0 with dest 3 -> RF unchanged; dest 2 with a=5 -> y=RF[5]; oe=0 -> y all Z.
REQ-026 FLAG_REG_EN: arithmetic op giving z=1, then logic op giving z=0 -> flags[1] remains 1.
